// File: rtl/jt08_snd_out_if.sv
// Stereo sample stream between the jt08 output stage and the audio sink.
//   snd_left/snd_right : signed 16-bit head sample (producer -> sink)
//   snd_valid          : head sample is present (producer -> sink)
//   snd_ready          : sink takes the head sample this clk (sink -> producer)
interface jt08_snd_out_if;
  logic signed [15:0] snd_left;
  logic signed [15:0] snd_right;
  logic               snd_valid;
  logic               snd_ready;

  modport master (
    output snd_left,
    output snd_right,
    output snd_valid,
    input  snd_ready
  );

  modport slave (
    input  snd_left,
    input  snd_right,
    input  snd_valid,
    output snd_ready
  );
endinterface

// File: rtl/jt08_snd_out.sv
// jt08 output stage: captures the accumulator's stereo sample at each sample boundary,
// optionally removes DC with a shift-only first-order high-pass, saturates to 16 bits and
// queues the result in a small stereo FIFO read through a ready/valid port.
//   clk, rst_n     : clock, synchronous active-low reset
//   clk_en, zero   : accumulator strobe and sample-boundary flag (capture request)
//   left, right    : signed accumulated samples
//   dc_en          : 1 = DC blocker active, 0 = bypass
//   snd            : stream port (head sample, valid, ready)
//   level          : FIFO occupancy 0..DEPTH
//   clip, drop     : sticky saturation / lost-sample flags
module jt08_snd_out #(
  parameter int unsigned DCK   = 9,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                zero,
  input  logic signed [15:0]  left,
  input  logic signed [15:0]  right,
  input  logic                dc_en,
  jt08_snd_out_if.master      snd,
  output logic [AW:0]         level,
  output logic                clip,
  output logic                drop
);

  typedef enum logic [2:0] {StIdle, StCapt, StFiltL, StFiltR, StPush} state_e;

  typedef struct packed {
    logic signed [17:0] y;
    logic signed [15:0] o;
    logic               clip;
  } filt_t;

  // One channel of the DC blocker: y' = sat18(x - x_prev + y - (y >>> DCK)), o = sat16(y').
  function automatic filt_t filt(input logic signed [15:0] x, input logic signed [15:0] xp,
                                 input logic signed [17:0] y, input logic en);
    filt_t              r;
    logic signed [18:0] xe, pe, ye, ys, v;
    xe = {{3{x[15]}}, x};
    pe = {{3{xp[15]}}, xp};
    ye = {y[17], y};
    ys = ye >>> DCK;
    v  = xe - pe + ye - ys;
    if (v > 19'sd131071)       r.y = 18'sd131071;
    else if (v < -19'sd131072) r.y = -18'sd131072;
    else                       r.y = v[17:0];
    r.clip = 1'b0;
    if (r.y > 18'sd32767) begin
      r.o    = 16'sh7fff;
      r.clip = 1'b1;
    end else if (r.y < -18'sd32768) begin
      r.o    = 16'sh8000;
      r.clip = 1'b1;
    end else begin
      r.o = r.y[15:0];
    end
    if (!en) begin
      r.y    = '0;
      r.o    = x;
      r.clip = 1'b0;
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic               pend_q, pend_d, drop_req, req;
  logic signed [15:0] xl_q, xr_q, xlp_q, xrp_q, outl_q, outr_q;
  logic signed [17:0] yl_q, yr_q;
  filt_t              fl, fr;

  logic [31:0]        mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [AW:0]        level_q, level_d;
  logic [31:0]        head_q, head_d;
  logic               push, pop, push_ok, clip_q, drop_q;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    drop_req = 1'b0;
    req      = clk_en & zero;
    case (state_q)
      StIdle: begin
        // A pending and a fresh request merge: capture reads the live inputs either way.
        if (req || pend_q) begin
          state_d = StCapt;
          pend_d  = 1'b0;
        end
      end
      StCapt:  state_d = StFiltL;
      StFiltL: state_d = StFiltR;
      StFiltR: state_d = StPush;
      StPush:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (req && state_q != StIdle) begin
      if (pend_q) drop_req = 1'b1;
      else        pend_d   = 1'b1;
    end
  end

  always_comb begin
    fl = filt(xl_q, xlp_q, yl_q, dc_en);
    fr = filt(xr_q, xrp_q, yr_q, dc_en);
  end

  always_comb begin
    push    = (state_q == StPush);
    pop     = snd.snd_valid & snd.snd_ready;
    push_ok = push & ((level_q < (AW+1)'(DEPTH)) | pop);
    rd_nxt  = rd_ptr_q + AW'(1);
    level_d = level_q;
    if (push_ok && !pop)      level_d = level_q + (AW+1)'(1);
    else if (pop && !push_ok) level_d = level_q - (AW+1)'(1);
    // Head register tracks the next entry; when the FIFO drains it keeps the last sample.
    head_d = head_q;
    if (pop) begin
      if (level_q >= (AW+1)'(2)) head_d = mem_q[rd_nxt];
      else if (push_ok)          head_d = {outl_q, outr_q};
    end else if (push_ok && level_q == '0) begin
      head_d = {outl_q, outr_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pend_q   <= 1'b0;
      xl_q     <= '0;
      xr_q     <= '0;
      xlp_q    <= '0;
      xrp_q    <= '0;
      yl_q     <= '0;
      yr_q     <= '0;
      outl_q   <= '0;
      outr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      clip_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (state_q == StCapt) begin
        xl_q <= left;
        xr_q <= right;
      end
      if (state_q == StFiltL) begin
        xlp_q  <= xl_q;
        yl_q   <= fl.y;
        outl_q <= fl.o;
        if (fl.clip) clip_q <= 1'b1;
      end
      if (state_q == StFiltR) begin
        xrp_q  <= xr_q;
        yr_q   <= fr.y;
        outr_q <= fr.o;
        if (fr.clip) clip_q <= 1'b1;
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_nxt;
      level_q <= level_d;
      head_q  <= head_d;
      if (drop_req || (push && !push_ok)) drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {outl_q, outr_q};
  end

  assign snd.snd_valid = (level_q != '0);
  assign snd.snd_left  = head_q[31:16];
  assign snd.snd_right = head_q[15:0];
  assign level         = level_q;
  assign clip          = clip_q;
  assign drop          = drop_q;

endmodule

// File: tb/tb_jt08_snd_out.sv
// Directed bench for jt08_snd_out: bypass latency, DC step response, clipping, FIFO
// full / full-with-pop, request overrun and mid-pipeline reset.
module tb_jt08_snd_out;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clk_en = 1'b0;
  logic               zero = 1'b0;
  logic signed [15:0] left = '0;
  logic signed [15:0] right = '0;
  logic               dc_en = 1'b0;
  logic [2:0]         level;
  logic               clip, drop;
  int                 checks = 0;
  int                 errors = 0;

  jt08_snd_out_if snd_if ();

  jt08_snd_out #(.DCK(9), .DEPTH(4), .AW(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .zero   (zero),
    .left   (left),
    .right  (right),
    .dc_en  (dc_en),
    .snd    (snd_if),
    .level  (level),
    .clip   (clip),
    .drop   (drop)
  );

  always #5 clk = ~clk;

  // Advance one posedge; sample/drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clk_en = 1'b0;
    zero = 1'b0;
    snd_if.snd_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Capture request at the next posedge (t); returns 1 unit after t.
  task automatic req_pulse(input logic signed [15:0] l, input logic signed [15:0] r);
    left = l;
    right = r;
    clk_en = 1'b1;
    zero = 1'b1;
    tick();
    clk_en = 1'b0;
    zero = 1'b0;
  endtask

  // Full sample: returns just after the FIFO write at t+4.
  task automatic sample(input logic signed [15:0] l, input logic signed [15:0] r);
    req_pulse(l, r);
    repeat (4) tick();
  endtask

  task automatic pop_one();
    snd_if.snd_ready = 1'b1;
    tick();
    snd_if.snd_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (snd_if.snd_left !== 16'sd0) begin errors++; $display("FAIL rst_left got %0d want 0", snd_if.snd_left); end
    if (snd_if.snd_right !== 16'sd0) begin errors++; $display("FAIL rst_right got %0d want 0", snd_if.snd_right); end
    if (snd_if.snd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", snd_if.snd_valid); end
    if (level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
    if (clip !== 1'b0) begin errors++; $display("FAIL rst_clip got %b want 0", clip); end
    if (drop !== 1'b0) begin errors++; $display("FAIL rst_drop got %b want 0", drop); end
  endtask

  // Caller resets beforehand.
  task automatic test_bypass();
    dc_en = 1'b0;
    req_pulse(16'sh1234, -16'sd5);
    repeat (3) tick();
    checks++;
    if (snd_if.snd_valid !== 1'b0) begin errors++; $display("FAIL byp_early_valid got %b want 0", snd_if.snd_valid); end
    tick();  // FIFO write at t+4; valid seen by the sink at edge t+5
    checks += 4;
    if (snd_if.snd_valid !== 1'b1) begin errors++; $display("FAIL byp_valid got %b want 1", snd_if.snd_valid); end
    if (snd_if.snd_left !== 16'sh1234) begin errors++; $display("FAIL byp_left got %h want 1234", snd_if.snd_left); end
    if (snd_if.snd_right !== -16'sd5) begin errors++; $display("FAIL byp_right got %0d want -5", snd_if.snd_right); end
    if (level !== 3'd1) begin errors++; $display("FAIL byp_level got %0d want 1", level); end
    pop_one();
    checks += 3;
    if (level !== 3'd0) begin errors++; $display("FAIL byp_pop_level got %0d want 0", level); end
    if (snd_if.snd_valid !== 1'b0) begin errors++; $display("FAIL byp_pop_valid got %b want 0", snd_if.snd_valid); end
    if (snd_if.snd_left !== 16'sh1234) begin errors++; $display("FAIL byp_hold got %h want 1234", snd_if.snd_left); end
  endtask

  task automatic test_dc_step();
    logic signed [15:0] want [4];
    want[0] = 16'sd1000;
    want[1] = 16'sd999;
    want[2] = 16'sd998;
    want[3] = 16'sd997;
    do_reset();
    dc_en = 1'b1;
    for (int i = 0; i < 4; i++) sample(16'sd1000, 16'sd1000);
    checks++;
    if (level !== 3'd4) begin errors++; $display("FAIL dc_level got %0d want 4", level); end
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (snd_if.snd_left !== want[i]) begin errors++; $display("FAIL dc_left[%0d] got %0d want %0d", i, snd_if.snd_left, want[i]); end
      if (snd_if.snd_right !== want[i]) begin errors++; $display("FAIL dc_right[%0d] got %0d want %0d", i, snd_if.snd_right, want[i]); end
      pop_one();
    end
    checks++;
    if (clip !== 1'b0) begin errors++; $display("FAIL dc_clip got %b want 0", clip); end
  endtask

  task automatic test_clip();
    do_reset();
    dc_en = 1'b1;
    sample(-16'sd32768, 16'sd0);
    checks++;
    if (clip !== 1'b0) begin errors++; $display("FAIL clip_first got %b want 0", clip); end
    sample(16'sd32767, 16'sd0);
    checks += 4;
    if (snd_if.snd_left !== -16'sd32768) begin errors++; $display("FAIL clip_head got %0d want -32768", snd_if.snd_left); end
    pop_one();
    if (snd_if.snd_left !== 16'sd32767) begin errors++; $display("FAIL clip_sat got %0d want 32767", snd_if.snd_left); end
    if (clip !== 1'b1) begin errors++; $display("FAIL clip_flag got %b want 1", clip); end
    if (drop !== 1'b0) begin errors++; $display("FAIL clip_drop got %b want 0", drop); end
    pop_one();
  endtask

  task automatic test_fifo_full();
    do_reset();
    dc_en = 1'b0;
    for (int i = 1; i <= 5; i++) sample(16'(100 * i + 1), 16'(-i));
    checks += 3;
    if (level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", level); end
    if (drop !== 1'b1) begin errors++; $display("FAIL full_drop got %b want 1", drop); end
    if (snd_if.snd_left !== 16'sd101) begin errors++; $display("FAIL full_head got %0d want 101", snd_if.snd_left); end
    for (int i = 1; i <= 4; i++) begin
      checks += 2;
      if (snd_if.snd_left !== 16'(100 * i + 1)) begin errors++; $display("FAIL full_pop_l[%0d] got %0d want %0d", i, snd_if.snd_left, 100 * i + 1); end
      if (snd_if.snd_right !== 16'(-i)) begin errors++; $display("FAIL full_pop_r[%0d] got %0d want %0d", i, snd_if.snd_right, -i); end
      pop_one();
    end
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL full_empty got %0d want 0", level); end
  endtask

  task automatic test_full_pop();
    do_reset();
    dc_en = 1'b0;
    for (int i = 1; i <= 4; i++) sample(16'(10 * i), 16'(i));
    req_pulse(16'sd50, 16'sd5);
    repeat (3) tick();  // now in PUSH
    pop_one();          // push and pop share this clk
    checks += 3;
    if (level !== 3'd4) begin errors++; $display("FAIL fpop_level got %0d want 4", level); end
    if (drop !== 1'b0) begin errors++; $display("FAIL fpop_drop got %b want 0", drop); end
    if (snd_if.snd_left !== 16'sd20) begin errors++; $display("FAIL fpop_head got %0d want 20", snd_if.snd_left); end
    for (int i = 2; i <= 5; i++) begin
      checks++;
      if (snd_if.snd_left !== 16'(10 * i)) begin errors++; $display("FAIL fpop_seq[%0d] got %0d want %0d", i, snd_if.snd_left, 10 * i); end
      pop_one();
    end
  endtask

  task automatic test_overrun_reset();
    do_reset();
    dc_en = 1'b0;
    left = 16'sd7;
    right = 16'sd8;
    clk_en = 1'b1;
    zero = 1'b1;
    repeat (3) tick();
    clk_en = 1'b0;
    zero = 1'b0;
    checks++;
    if (drop !== 1'b1) begin errors++; $display("FAIL ovr_drop got %b want 1", drop); end
    repeat (12) tick();
    checks++;
    if (level !== 3'd2) begin errors++; $display("FAIL ovr_level got %0d want 2", level); end
    req_pulse(16'sd99, 16'sd98);
    tick();             // now in FILT_L
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks += 5;
    if (snd_if.snd_left !== 16'sd0) begin errors++; $display("FAIL mid_rst_left got %0d want 0", snd_if.snd_left); end
    if (snd_if.snd_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", snd_if.snd_valid); end
    if (level !== 3'd0) begin errors++; $display("FAIL mid_rst_level got %0d want 0", level); end
    if (drop !== 1'b0) begin errors++; $display("FAIL mid_rst_drop got %b want 0", drop); end
    if (clip !== 1'b0) begin errors++; $display("FAIL mid_rst_clip got %b want 0", clip); end
    repeat (6) tick();
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL mid_rst_flush got %0d want 0", level); end
    test_bypass();
  endtask

  initial begin
    snd_if.snd_ready = 1'b0;
    #1;
    test_reset();
    test_bypass();
    test_dc_step();
    test_clip();
    test_fifo_full();
    test_full_pop();
    test_overrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
